// File: rtl/imm_extend_pipe_if.sv
// Decode-to-execute immediate bus: input handshake, output handshake and delivery counter.
interface imm_extend_pipe_if #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
);
    logic             in_valid;
    logic             in_ready;
    logic [IN_W-1:0]  in_imm;
    logic [1:0]       in_mode;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic [OUT_W-1:0] out_data;
    logic [TAG_W-1:0] out_tag;
    logic [15:0]      out_count;

    modport slave (
        input  in_valid, in_imm, in_mode, in_tag, out_ready,
        output in_ready, out_valid, out_data, out_tag, out_count
    );

    modport master (
        output in_valid, in_imm, in_mode, in_tag, out_ready,
        input  in_ready, out_valid, out_data, out_tag, out_count
    );
endinterface

// File: rtl/imm_extend_pipe.sv
// Single-cycle immediate extender (SEXT/ZEXT/UPPER/BOFS) with a main register backed by
// a one-word skid register, so in_ready depends only on local state.
module imm_extend_pipe #(
    parameter int IN_W  = 16,
    parameter int OUT_W = 32,
    parameter int TAG_W = 5
) (
    input logic              clk,
    input logic              rst_n,
    imm_extend_pipe_if.slave bus
);
    localparam int PAD = OUT_W - IN_W;
    localparam logic [1:0] M_SEXT  = 2'b00;
    localparam logic [1:0] M_ZEXT  = 2'b01;
    localparam logic [1:0] M_UPPER = 2'b10;
    localparam logic [1:0] M_BOFS  = 2'b11;

    typedef struct packed {
        logic [OUT_W-1:0] data;
        logic [TAG_W-1:0] tag;
    } word_t;

    word_t       main_q, skid_q, nxt;
    logic        main_vld, skid_vld;
    logic [15:0] count;
    logic [OUT_W-1:0] sext;
    logic        accept, drain;

    always_comb begin
        sext     = {{PAD{bus.in_imm[IN_W-1]}}, bus.in_imm};
        nxt.tag  = bus.in_tag;
        nxt.data = '0;
        case (bus.in_mode)
            M_SEXT:  nxt.data = sext;
            M_ZEXT:  nxt.data = {{PAD{1'b0}}, bus.in_imm};
            M_UPPER: nxt.data = {bus.in_imm, {PAD{1'b0}}};
            M_BOFS:  nxt.data = {sext[OUT_W-3:0], 2'b00};
            default: nxt.data = '0;
        endcase
    end

    // Skid full is the only condition that blocks upstream.
    assign accept = bus.in_valid & ~skid_vld;
    assign drain  = main_vld & bus.out_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q   <= '0;
            skid_q   <= '0;
            main_vld <= 1'b0;
            skid_vld <= 1'b0;
            count    <= '0;
        end else begin
            if (drain) begin
                count <= count + 16'd1;
                if (skid_vld) begin
                    main_q   <= skid_q;
                    skid_vld <= 1'b0;
                end else if (accept) begin
                    main_q <= nxt;
                end else begin
                    main_vld <= 1'b0;
                end
            end else if (accept) begin
                if (main_vld) begin
                    skid_q   <= nxt;
                    skid_vld <= 1'b1;
                end else begin
                    main_q   <= nxt;
                    main_vld <= 1'b1;
                end
            end
        end
    end

    assign bus.in_ready  = ~skid_vld;
    assign bus.out_valid = main_vld;
    assign bus.out_data  = main_q.data;
    assign bus.out_tag   = main_q.tag;
    assign bus.out_count = count;
endmodule
